led_pwm: RTL and testbench

CSR-bus peripheral that drives the board LEDs with 8 independent PWM channels. It sits on the CSR bridge alongside the GPIO, UART and system controller, decodes its own 4-bit bank select, and ORs its read data into the bridge's shared read bus. Its `pwm_out[7:0]` replaces the GPIO-driven `led[7:0]` at top level. Duty updates are double-buffered so that every PWM period is glitch-free.

---
 rtl/led_pwm_if.sv | 10 +
 rtl/led_pwm.sv | 143 ++++++++++++++
 tb/tb_led_pwm.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_if.sv
// CSR bridge signals seen by the led_pwm peripheral.
interface led_pwm_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/led_pwm.sv
// 8-channel LED PWM on the CSR bridge; duty and period are double-buffered per PWM period.
// Define LED_PWM_FADE_EN to step each duty shadow by +-1 per wrap instead of loading it.
module led_pwm #(
  parameter logic [3:0] csr_addr = 4'h4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  led_pwm_if.slave   csr,
  output logic [7:0] pwm_out
);
  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned PW  = 16;
  localparam int unsigned RW  = 32;

  logic [1:0]             ctrl_q, ctrl_d;
  logic [PW-1:0]          prescale_q, prescale_d;
  logic [PW-1:0]          pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]          period_q, period_d;
  logic [DW-1:0]          per_sh_q, per_sh_d;
  logic [DW-1:0]          per_cnt_q, per_cnt_d;
  logic [RW-1:0]          wraps_q, wraps_d;
  logic [RW-1:0]          csr_do_q, csr_do_d;
  logic [NCH-1:0][DW-1:0] duty_q, duty_d;
  logic [NCH-1:0][DW-1:0] duty_sh_q, duty_sh_d;
  logic [NCH-1:0]         pwm_out_q, pwm_out_d;
  logic [NCH-1:0]         active_c;

  logic       sel_c, wr_c, en_rise_c, tick_c, wrap_c;
  logic [3:0] off_c;
  logic       unused_c;

  assign off_c     = csr.csr_a[3:0];
  assign sel_c     = (csr.csr_a[13:10] == csr_addr);
  assign wr_c      = sel_c && csr.csr_we;
  assign en_rise_c = wr_c && (off_c == 4'd0) && csr.csr_di[0] && !ctrl_q[0];
  // >= keeps the prescaler from running away if PRESCALE is lowered mid-count
  assign tick_c    = (pre_cnt_q >= prescale_q);
  assign wrap_c    = tick_c && (per_cnt_q >= per_sh_q);
  assign unused_c  = ^{csr.csr_a[9:4], csr.csr_di[31:16]};

  // Programmer-visible registers
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    duty_d     = duty_q;
    if (wr_c) begin
      case (off_c)
        4'd0:    ctrl_d     = csr.csr_di[1:0];
        4'd1:    prescale_d = csr.csr_di[PW-1:0];
        4'd2:    period_d   = csr.csr_di[DW-1:0];
        default: if (off_c[3]) duty_d[off_c[2:0]] = csr.csr_di[DW-1:0];
      endcase
    end
  end

  // Prescaler, period counter, shadow reload and wrap count
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    per_cnt_d = per_cnt_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    wraps_d   = wraps_q;
    if (en_rise_c) begin
      pre_cnt_d = '0;
      per_cnt_d = '0;
      per_sh_d  = period_q;
      duty_sh_d = duty_q;
    end else if (ctrl_q[0]) begin
      if (!tick_c) begin
        pre_cnt_d = pre_cnt_q + PW'(1);
      end else begin
        pre_cnt_d = '0;
        if (!wrap_c) begin
          per_cnt_d = per_cnt_q + DW'(1);
        end else begin
          per_cnt_d = '0;
          per_sh_d  = period_q;
          wraps_d   = wraps_q + RW'(1);
          for (int n = 0; n < NCH; n++) begin
`ifdef LED_PWM_FADE_EN
            if (duty_sh_q[n] < duty_q[n])      duty_sh_d[n] = duty_sh_q[n] + DW'(1);
            else if (duty_sh_q[n] > duty_q[n]) duty_sh_d[n] = duty_sh_q[n] - DW'(1);
`else
            duty_sh_d[n] = duty_q[n];
`endif
          end
        end
      end
    end
    // A WRAPS write beats a simultaneous wrap
    if (wr_c && (off_c == 4'd3)) wraps_d = '0;
  end

  // LED drive and read-data mux
  always_comb begin
    active_c = '0;
    for (int n = 0; n < NCH; n++) active_c[n] = (per_cnt_q < duty_sh_q[n]);
    pwm_out_d = ctrl_q[0] ? (active_c ^ {NCH{ctrl_q[1]}}) : {NCH{ctrl_q[1]}};
    csr_do_d  = '0;
    if (sel_c) begin
      case (off_c)
        4'd0:    csr_do_d = RW'(ctrl_q);
        4'd1:    csr_do_d = RW'(prescale_q);
        4'd2:    csr_do_d = RW'(period_q);
        4'd3:    csr_do_d = wraps_q;
        default: if (off_c[3]) csr_do_d = RW'(duty_q[off_c[2:0]]);
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      period_q   <= 8'hFF;
      wraps_q    <= '0;
      duty_q     <= '0;
      duty_sh_q  <= '0;
      per_sh_q   <= 8'hFF;
      pre_cnt_q  <= '0;
      per_cnt_q  <= '0;
      pwm_out_q  <= '0;
      csr_do_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      period_q   <= period_d;
      wraps_q    <= wraps_d;
      duty_q     <= duty_d;
      duty_sh_q  <= duty_sh_d;
      per_sh_q   <= per_sh_d;
      pre_cnt_q  <= pre_cnt_d;
      per_cnt_q  <= per_cnt_d;
      pwm_out_q  <= pwm_out_d;
      csr_do_q   <= csr_do_d;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign csr.csr_do = csr_do_q;
endmodule

// File: tb/tb_led_pwm.sv
// Scoreboard bench for led_pwm: a period-level reference model predicts every pwm_out cycle and CSR read.
module tb_led_pwm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pwm_out;

  led_pwm_if bus ();

  led_pwm #(.csr_addr(4'h4)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .csr     (bus),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  pwm_q [$];
  logic        rd_issue = 1'b0;
  logic        rd_vld   = 1'b0;

  // Reference model state: registers as written, plus the values in force for the current period
  logic [7:0]  m_duty [8];
  logic [7:0]  m_sh [8];
  logic [7:0]  m_period_reg, m_per;
  logic [15:0] m_pre;
  logic        m_inv, m_en, m_fresh;
  int          m_wraps;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, want, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 8; n++) begin
      m_duty[n] = 8'd0;
      m_sh[n]   = 8'd0;
    end
    m_period_reg = 8'hFF;
    m_per        = 8'hFF;
    m_pre        = 16'd0;
    m_inv        = 1'b0;
    m_en         = 1'b0;
    m_fresh      = 1'b1;
    m_wraps      = 0;
  endfunction

  // Queue one full PWM period; the boundary update is applied at the start of each later period
  function automatic void model_period();
    int         len;
    logic [7:0] v;
    if (!m_fresh) begin
      for (int n = 0; n < 8; n++) begin
`ifdef LED_PWM_FADE_EN
        if (m_sh[n] < m_duty[n])      m_sh[n] = m_sh[n] + 8'd1;
        else if (m_sh[n] > m_duty[n]) m_sh[n] = m_sh[n] - 8'd1;
`else
        m_sh[n] = m_duty[n];
`endif
      end
      m_per = m_period_reg;
    end
    m_fresh = 1'b0;
    len = (int'(m_per) + 1) * (int'(m_pre) + 1);
    for (int c = 0; c < len; c++) begin
      for (int n = 0; n < 8; n++) v[n] = (c < int'(m_sh[n]) * (int'(m_pre) + 1)) ^ m_inv;
      pwm_q.push_back(v);
    end
    m_wraps++;
  endfunction

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] bank);
    bus.csr_a  = {bank, 6'd0, off};
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    @(posedge clk);
    #1;
    bus.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] want, input logic [3:0] bank);
    bus.csr_a = {bank, 6'd0, off};
    rd_issue  = 1'b1;
    rd_q.push_back(want);
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic mwr(input logic [3:0] off, input logic [31:0] d);
    logic old_inv;
    old_inv = m_inv;
    wr(off, d, 4'h4);
    case (off)
      4'd0: begin
        m_inv = d[1];
        if (d[0] && !m_en) begin
          for (int n = 0; n < 8; n++) m_sh[n] = m_duty[n];
          m_per   = m_period_reg;
          m_fresh = 1'b1;
          pwm_q.push_back({8{old_inv}});
        end
        m_en = d[0];
      end
      4'd1:    m_pre = d[15:0];
      4'd2:    m_period_reg = d[7:0];
      4'd3:    m_wraps = 0;
      default: if (off[3]) m_duty[off[2:0]] = d[7:0];
    endcase
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pwm_q.size() > 0 && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pwm_q.size() > 0) begin
      check("pwm_drain_timeout", 32'(pwm_q.size()), 32'd0);
      pwm_q.delete();
    end
  endtask

  always @(posedge clk) rd_vld <= rd_issue;

  // Monitor: pops expected values whenever the DUT presents read data or a PWM sample
  always @(negedge clk) begin
    logic [31:0] e32;
    logic [7:0]  e8;
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL csr_do_unexpected: got 0x%0h, expected no read", bus.csr_do);
      end else begin
        e32 = rd_q.pop_front();
        check("csr_do", bus.csr_do, e32);
      end
    end
    if (pwm_q.size() > 0) begin
      e8 = pwm_q.pop_front();
      check("pwm_out", {24'd0, pwm_out}, {24'd0, e8});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, s, len, k, ch;
    logic       inv;
    logic [3:0] o;

    bus.csr_a  = '0;
    bus.csr_we = 1'b0;
    bus.csr_di = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset while running with an always-on channel
    mwr(4'd2, 32'd5);
    mwr(4'd8, 32'd9);
    mwr(4'd0, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    rd(4'd2, 32'd5, 4'h4);
    repeat (2) @(posedge clk);
    #3;
    check("pwm_before_rst", {24'd0, pwm_out}, 32'h1);
    rst = 1'b1;
    #1;
    check("pwm_in_rst", {24'd0, pwm_out}, 32'h0);
    check("csr_do_in_rst", bus.csr_do, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    rd(4'd0, 32'h0, 4'h4);
    rd(4'd1, 32'h0, 4'h4);
    rd(4'd2, 32'hFF, 4'h4);
    rd(4'd3, 32'h0, 4'h4);
    rd(4'd8, 32'h0, 4'h4);

    // Basic duty, double buffering, boundary duties and fade ramp
    mwr(4'd3, 32'd0);
    mwr(4'd1, 32'd0);
    mwr(4'd2, 32'd9);
    mwr(4'd8, 32'd3);
    mwr(4'd9, 32'd2);
    mwr(4'd10, 32'd0);
    mwr(4'd11, 32'd10);
    mwr(4'd12, 32'd0);
    mwr(4'd0, 32'd1);
    model_period();
    repeat (4) @(posedge clk);
    #1;
    mwr(4'd9, 32'd8);
    mwr(4'd12, 32'd5);
    for (int i = 0; i < 5; i++) model_period();
    repeat (18) @(posedge clk);
    #1;
    rd(4'd3, 32'd2, 4'h4);
    drain();
    mwr(4'd0, 32'd0);
    rd(4'd3, 32'(m_wraps), 4'h4);

    // Inverted output, then disabled output frozen at the invert level
    mwr(4'd0, 32'd2);
    mwr(4'd0, 32'd3);
    model_period();
    model_period();
    drain();
    mwr(4'd0, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) pwm_q.push_back(8'hFF);
    drain();
    rd(4'd3, 32'(m_wraps), 4'h4);

    // Bank select, ignored offsets and unused register bits
    rd(4'd2, 32'h0, 4'h5);
    rd(4'd2, 32'(m_period_reg), 4'h4);
    wr(4'd8, 32'd77, 4'h5);
    rd(4'd8, 32'(m_duty[0]), 4'h4);
    mwr(4'd5, 32'h1234);
    rd(4'd5, 32'h0, 4'h4);
    mwr(4'd0, 32'hFFFF_FFFC);
    rd(4'd0, 32'h0, 4'h4);
    mwr(4'd1, 32'hABCD_0003);
    rd(4'd1, 32'h3, 4'h4);

    // WRAPS write landing exactly on a wrap edge (PRESCALE=1, PERIOD=3 -> 8-cycle period)
    mwr(4'd1, 32'd1);
    mwr(4'd2, 32'd3);
    mwr(4'd3, 32'd0);
    mwr(4'd0, 32'd1);
    repeat (15) @(posedge clk);
    #1;
    wr(4'd3, 32'hFFFF_FFFF, 4'h4);
    rd(4'd3, 32'd0, 4'h4);
    repeat (15) @(posedge clk);
    #1;
    mwr(4'd0, 32'd0);
    rd(4'd3, 32'd2, 4'h4);

    // Randomised configurations with a mid-period duty (and sometimes period) change
    for (int it = 0; it < 6; it++) begin
      inv = 1'($urandom_range(0, 1));
      p   = int'($urandom_range(2, 12));
      s   = int'($urandom_range(0, 2));
      mwr(4'd0, {30'd0, inv, 1'b0});
      mwr(4'd1, 32'(s));
      mwr(4'd2, 32'(p));
      mwr(4'd3, 32'd0);
      for (int n = 0; n < 8; n++) mwr(4'(8 + n), 32'($urandom_range(0, p + 2)));
      ch = int'($urandom_range(0, 7));
      o  = 4'(8 + ch);
      rd(o, 32'(m_duty[ch]), 4'h4);
      rd(4'd0, {30'd0, inv, 1'b0}, 4'h4);
      mwr(4'd0, {30'd0, inv, 1'b1});
      model_period();
      len = (p + 1) * (s + 1);
      k   = int'($urandom_range(0, len - 3));
      repeat (k) @(posedge clk);
      #1;
      ch = int'($urandom_range(0, 7));
      mwr(4'(8 + ch), 32'($urandom_range(0, p + 2)));
      if ($urandom_range(0, 1) == 1) mwr(4'd2, 32'($urandom_range(1, 12)));
      model_period();
      model_period();
      drain();
      mwr(4'd0, {30'd0, inv, 1'b0});
      rd(4'd3, 32'(m_wraps), 4'h4);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
